// File: rtl/sync_updown_counter.sv
// Parametrised up/down modulo-MOD counter with clear, parallel load, wrap/saturate
// ends, terminal count and one-cycle wrap / out-of-range-load status pulses.
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (WIDTH < 1 || MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_params
      $error("sync_updown_counter: need WIDTH>=1 and 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             wrap_reg, wrap_next;
  logic             load_err_reg, load_err_next;

  always_comb begin
    q_next        = q_reg;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (clear) begin
      q_next = '0;
    end else if (load) begin
      // Out-of-range loads clamp to the top of the legal range.
      if ({1'b0, load_val} < MOD_W) begin
        q_next = load_val;
      end else begin
        q_next        = TOP;
        load_err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q_reg != TOP) begin
          q_next = q_reg + ONE;
        end else if (SATURATE == 0) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (q_reg != '0) begin
          q_next = q_reg - ONE;
        end else if (SATURATE == 0) begin
          q_next    = TOP;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg        <= '0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  assign q        = q_reg;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;
  assign tc       = up ? (q_reg == TOP) : (q_reg == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench for sync_updown_counter: four instances (MOD 16, 10, 10 saturating,
// and 2 on one bit) share stimulus; each scenario task checks the instance it targets.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, clear, load;
  logic [3:0] load_val;

  logic [3:0] q16, q10, qs;
  logic [0:0] q2;
  logic       tc16, w16, e16, tc10, w10, e10, tcs, ws, es, tc2, w2, e2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic       lerr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) d16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q16), .tc(tc16), .wrap(w16), .load_err(e16));

  sync_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) d10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q10), .tc(tc10), .wrap(w10), .load_err(e10));

  sync_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) ds (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(qs), .tc(tcs), .wrap(ws), .load_err(es));

  sync_updown_counter #(.WIDTH(1), .MOD(2), .SATURATE(0)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val[0:0]), .q(q2), .tc(tc2), .wrap(w2), .load_err(e2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] v);
    en = e; up = u; clear = c; load = l; load_val = v;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = '{q: 4'd0, tc: 1'b0, wrap: 1'b0, lerr: 1'b0};
      sb.push_back(e);
      e = sb.pop_front();
      n_vec++;
      if ({q16, w16, e16, q10, w10, e10, qs, ws, es, q2, w2, e2} !==
          {e.q, e.wrap, e.lerr, e.q, e.wrap, e.lerr, e.q, e.wrap, e.lerr, e.q[0], e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL reset[%0d]: q16=%0d q10=%0d qs=%0d q2=%0d wrap=%b%b%b%b lerr=%b%b%b%b, expected all q=0 wrap=0 lerr=0",
                 k, q16, q10, qs, q2, w16, w10, ws, w2, e16, e10, es, e2);
      end else
        $display("reset[%0d]: all instances q=0 wrap=0 load_err=0", k);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_legacy();
    exp_t e;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      e.q = 4'(i % 16); e.tc = (i % 16 == 15); e.wrap = (i % 16 == 0); e.lerr = 1'b0;
      sb.push_back(e);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({q16, tc16, w16, e16} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL legacy[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q16, tc16, w16, e16, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("legacy[%0d]: q=%0d tc=%b wrap=%b", i, q16, tc16, w16);
    end
  endtask

  task automatic test_decade_down();
    exp_t e;
    logic [3:0] qv [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e.q = qv[i]; e.tc = (qv[i] == 4'd0); e.wrap = (i == 3); e.lerr = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
      else        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({q10, tc10, w10, e10} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL decade_down[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q10, tc10, w10, e10, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("decade_down[%0d]: q=%0d tc=%b wrap=%b", i, q10, tc10, w10);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    // Columns: en, up, load, load_val, expected q, expected tc.
    logic [3:0] cfg [10][6] = '{
      '{0, 1, 1, 7, 7, 0}, '{1, 1, 0, 0, 8, 0}, '{1, 1, 0, 0, 9, 1}, '{1, 1, 0, 0, 9, 1},
      '{1, 1, 0, 0, 9, 1}, '{1, 1, 0, 0, 9, 1}, '{1, 0, 0, 0, 8, 0}, '{0, 0, 1, 1, 1, 0},
      '{1, 0, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 1}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      e.q = cfg[i][4]; e.tc = cfg[i][5][0]; e.wrap = 1'b0; e.lerr = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      drive(cfg[i][0][0], cfg[i][1][0], 1'b0, cfg[i][2][0], cfg[i][3]);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({qs, tcs, ws, es} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL saturate[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, qs, tcs, ws, es, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("saturate[%0d]: q=%0d tc=%b wrap=%b", i, qs, tcs, ws);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    // Columns: en, clear, load, load_val, expected q, expected tc, expected load_err.
    logic [3:0] cfg [7][7] = '{
      '{0, 0, 1, 5, 5, 0, 0}, '{1, 1, 1, 3, 0, 0, 0}, '{0, 0, 1, 12, 9, 1, 1},
      '{1, 0, 1, 4, 4, 0, 0}, '{0, 0, 0, 0, 4, 0, 0}, '{0, 0, 1, 15, 9, 1, 1},
      '{1, 1, 0, 0, 0, 0, 0}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      e.q = cfg[i][4]; e.tc = cfg[i][5][0]; e.wrap = 1'b0; e.lerr = cfg[i][6][0];
      sb.push_back(e);
    end
    for (int i = 0; i < 7; i++) begin
      drive(cfg[i][0][0], 1'b1, cfg[i][1][0], cfg[i][2][0], cfg[i][3]);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({q10, tc10, w10, e10} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL priority[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q10, tc10, w10, e10, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("priority[%0d]: q=%0d tc=%b load_err=%b", i, q10, tc10, e10);
      if (i == 2) begin
        // The same load of 12 is in range for the modulus-16 instance.
        n_vec++;
        if ({q16, e16} !== {4'd12, 1'b0}) begin
          n_err++;
          $display("FAIL load_in_range_mod16: q=%0d lerr=%b, expected q=12 lerr=0", q16, e16);
        end else
          $display("load_in_range_mod16: q=%0d load_err=%b", q16, e16);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) tick();
    e = '{q: 4'd6, tc: 1'b0, wrap: 1'b0, lerr: 1'b0};
    sb.push_back(e);
    e = '{q: 4'd0, tc: 1'b0, wrap: 1'b0, lerr: 1'b0};
    for (int i = 0; i < 4; i++) sb.push_back(e);
    for (int i = 1; i <= 3; i++) begin
      e.q = 4'(i);
      sb.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        #2 rst = 1'b1;
        #1;
      end else if (i >= 2 && i <= 4) begin
        tick();
        if (i == 4) rst = 1'b0;
      end else if (i >= 5) begin
        tick();
      end
      e = sb.pop_front();
      n_vec++;
      if ({q10, tc10, w10, e10} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL async_reset[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q10, tc10, w10, e10, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("async_reset[%0d]: rst=%b q=%0d wrap=%b", i, rst, q10, w10);
    end
  endtask

  task automatic test_enable();
    exp_t e;
    logic       env [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] qv  [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e = '{q: qv[i], tc: 1'b0, wrap: 1'b0, lerr: 1'b0};
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      drive(env[i], 1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({q16, tc16, w16, e16} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL enable[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q16, tc16, w16, e16, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("enable[%0d]: en=%b q=%0d", i, env[i], q16);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic upv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic qv  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic tcv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic wv  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e = '{q: {3'b000, qv[i]}, tc: tcv[i], wrap: wv[i], lerr: 1'b0};
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, upv[i], 1'b0, 1'b0, 4'd0);
      tick();
      e = sb.pop_front();
      n_vec++;
      if ({3'b000, q2, tc2, w2, e2} !== {e.q, e.tc, e.wrap, e.lerr}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: q=%0d tc=%b wrap=%b lerr=%b, expected q=%0d tc=%b wrap=%b lerr=%b",
                 i, q2, tc2, w2, e2, e.q, e.tc, e.wrap, e.lerr);
      end else
        $display("back_to_back[%0d]: up=%b q=%0d wrap=%b", i, upv[i], q2, w2);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_legacy();
    test_decade_down();
    test_saturate();
    test_priority();
    test_async_reset();
    test_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
